// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU operation, ALUOp class and funct code constants
package alu_pkg;

    // ALU operation codes, identical to the result mux select codes downstream
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    // Main-control ALU classes
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_SLTI  = 2'b11;

    // Supported R-type funct fields
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;
    localparam logic [5:0] FUNCT_NOR = 6'b100111;

endpackage

// File: rtl/alu_controle.sv
// rtl/alu_controle.sv - combinational ALU control decode (aluop, funct) -> (seletor, ilegal)
//
// Ports:
//   aluop   in  2  main-control ALU class
//   funct   in  6  instruction funct field
//   seletor out 4  ALU operation code (always one of the six legal codes)
//   ilegal  out 1  aluop is R-type and funct is not supported
module alu_controle
    import alu_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [3:0] seletor,
    output logic       ilegal
);

    always_comb begin
        seletor = ALU_ADD;
        ilegal  = 1'b0;
        unique case (aluop)
            ALUOP_ADD:  seletor = ALU_ADD;
            ALUOP_SUB:  seletor = ALU_SUB;
            ALUOP_SLTI: seletor = ALU_SLT;
            ALUOP_RTYPE: begin
                case (funct)
                    FUNCT_ADD: seletor = ALU_ADD;
                    FUNCT_SUB: seletor = ALU_SUB;
                    FUNCT_AND: seletor = ALU_AND;
                    FUNCT_OR:  seletor = ALU_OR;
                    FUNCT_SLT: seletor = ALU_SLT;
                    FUNCT_NOR: seletor = ALU_NOR;
                    default: begin
                        // Unsupported funct falls back to add so the mux never sees an undefined code
                        seletor = ALU_ADD;
                        ilegal  = 1'b1;
                    end
                endcase
            end
            default: seletor = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/estagio_ex_alu_controle.sv
// rtl/estagio_ex_alu_controle.sv - ID/EX stage registers with ALU selector decode, stall and flush
//
// Ports:
//   clock        in   1        rising-edge clock
//   reset        in   1        asynchronous active-low reset
//   valido_in    in   1        decode presents a valid instruction
//   stall        in   1        hold all stage registers
//   flush        in   1        write a bubble (wins over stall)
//   aluop        in   2        main-control ALU class
//   funct        in   6        instruction funct field
//   alusrc       in   1        1 = operand B from imediato, 0 = from reg_b
//   reg_a        in   LARGURA  register read data A
//   reg_b        in   LARGURA  register read data B
//   imediato     in   LARGURA  sign-extended immediate
//   valido_out   out  1        stage holds a valid instruction
//   seletor      out  4        registered ALU operation code
//   operando_a   out  LARGURA  registered operand A
//   operando_b   out  LARGURA  registered operand B
//   funct_ilegal out  1        registered unsupported-funct flag
module estagio_ex_alu_controle
    import alu_pkg::*;
#(
    parameter int LARGURA = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               valido_in,
    input  logic               stall,
    input  logic               flush,
    input  logic [1:0]         aluop,
    input  logic [5:0]         funct,
    input  logic               alusrc,
    input  logic [LARGURA-1:0] reg_a,
    input  logic [LARGURA-1:0] reg_b,
    input  logic [LARGURA-1:0] imediato,
    output logic               valido_out,
    output logic [3:0]         seletor,
    output logic [LARGURA-1:0] operando_a,
    output logic [LARGURA-1:0] operando_b,
    output logic               funct_ilegal
);

    logic [3:0]         seletor_dec;
    logic               ilegal_dec;
    logic [LARGURA-1:0] operando_b_dec;

    alu_controle u_alu_controle (
        .aluop   (aluop),
        .funct   (funct),
        .seletor (seletor_dec),
        .ilegal  (ilegal_dec)
    );

    assign operando_b_dec = alusrc ? imediato : reg_b;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valido_out   <= 1'b0;
            seletor      <= ALU_ADD;
            operando_a   <= '0;
            operando_b   <= '0;
            funct_ilegal <= 1'b0;
        end else if (flush) begin
            // Bubble is indistinguishable from the reset state
            valido_out   <= 1'b0;
            seletor      <= ALU_ADD;
            operando_a   <= '0;
            operando_b   <= '0;
            funct_ilegal <= 1'b0;
        end else if (!stall) begin
            // Data registers load even for invalid slots; consumers qualify with valido_out
            valido_out   <= valido_in;
            seletor      <= seletor_dec;
            operando_a   <= reg_a;
            operando_b   <= operando_b_dec;
            funct_ilegal <= ilegal_dec & valido_in;
        end
    end

endmodule

// File: tb/tb_estagio_ex_alu_controle.sv
// tb/tb_estagio_ex_alu_controle.sv - scoreboard bench for estagio_ex_alu_controle
module tb_estagio_ex_alu_controle;

    typedef struct {
        logic        v;
        logic [3:0]  sel;
        logic [31:0] a;
        logic [31:0] b;
        logic        il;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        valido_in = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [1:0]  aluop = 2'b00;
    logic [5:0]  funct = 6'b0;
    logic        alusrc = 1'b0;
    logic [31:0] reg_a = '0;
    logic [31:0] reg_b = '0;
    logic [31:0] imediato = '0;
    logic        valido_out;
    logic [3:0]  seletor;
    logic [31:0] operando_a;
    logic [31:0] operando_b;
    logic        funct_ilegal;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    event chk_evt;

    estagio_ex_alu_controle #(.LARGURA(32)) dut (
        .clock        (clock),
        .reset        (reset),
        .valido_in    (valido_in),
        .stall        (stall),
        .flush        (flush),
        .aluop        (aluop),
        .funct        (funct),
        .alusrc       (alusrc),
        .reg_a        (reg_a),
        .reg_b        (reg_b),
        .imediato     (imediato),
        .valido_out   (valido_out),
        .seletor      (seletor),
        .operando_a   (operando_a),
        .operando_b   (operando_b),
        .funct_ilegal (funct_ilegal)
    );

    always #5 clock = ~clock;

    // Monitor: compares after each edge or on an asynchronous-check request
    initial begin
        exp_t e;
        forever begin
            @(posedge clock or chk_evt);
            #1;
            while (q.size() > 0) begin
                e = q.pop_front();
                n_vec++;
                if (valido_out !== e.v || seletor !== e.sel || operando_a !== e.a ||
                    operando_b !== e.b || funct_ilegal !== e.il) begin
                    n_err++;
                    $display("FAIL vec%0d: got v=%b sel=%b a=%h b=%h il=%b, expected v=%b sel=%b a=%h b=%h il=%b",
                             n_vec, valido_out, seletor, operando_a, operando_b, funct_ilegal,
                             e.v, e.sel, e.a, e.b, e.il);
                end
            end
        end
    end

    task automatic step(input logic vi, input logic st, input logic fl, input logic [1:0] op,
                        input logic [5:0] fn, input logic src, input logic [31:0] ra,
                        input logic [31:0] rb, input logic [31:0] im,
                        input logic ev, input logic [3:0] esel, input logic [31:0] ea,
                        input logic [31:0] eb, input logic eil);
        exp_t e;
        @(negedge clock);
        valido_in = vi; stall = st; flush = fl; aluop = op; funct = fn;
        alusrc = src; reg_a = ra; reg_b = rb; imediato = im;
        @(posedge clock);
        e.v = ev; e.sel = esel; e.a = ea; e.b = eb; e.il = eil;
        q.push_back(e);
    endtask

    task automatic check_now(input logic ev, input logic [3:0] esel, input logic [31:0] ea,
                             input logic [31:0] eb, input logic eil);
        exp_t e;
        e.v = ev; e.sel = esel; e.a = ea; e.b = eb; e.il = eil;
        q.push_back(e);
        ->chk_evt;
    endtask

    initial begin
        // Power-up asynchronous reset
        #1 reset = 1'b0;
        #1 check_now(1'b0, 4'b0010, 32'h0, 32'h0, 1'b0);
        #3;
        @(negedge clock);
        reset = 1'b1;

        // R-type sweep
        step(1,0,0,2'b10,6'b100000,0,32'h0000_0011,32'h0000_0021,32'h0, 1,4'b0010,32'h0000_0011,32'h0000_0021,0);
        step(1,0,0,2'b10,6'b100010,0,32'h0000_0012,32'h0000_0022,32'h0, 1,4'b0110,32'h0000_0012,32'h0000_0022,0);
        step(1,0,0,2'b10,6'b100100,0,32'h0000_0013,32'h0000_0023,32'h0, 1,4'b0000,32'h0000_0013,32'h0000_0023,0);
        step(1,0,0,2'b10,6'b100101,0,32'h0000_0014,32'h0000_0024,32'h0, 1,4'b0001,32'h0000_0014,32'h0000_0024,0);
        step(1,0,0,2'b10,6'b101010,0,32'h0000_0015,32'h0000_0025,32'h0, 1,4'b0111,32'h0000_0015,32'h0000_0025,0);
        step(1,0,0,2'b10,6'b100111,0,32'h0000_0016,32'h0000_0026,32'h0, 1,4'b1100,32'h0000_0016,32'h0000_0026,0);

        // Illegal funct, then same funct under a non-R-type class
        step(1,0,0,2'b10,6'b000000,0,32'hA5A5_A5A5,32'h5A5A_5A5A,32'h0, 1,4'b0010,32'hA5A5_A5A5,32'h5A5A_5A5A,1);
        step(1,0,0,2'b00,6'b000000,0,32'hA5A5_A5A5,32'h5A5A_5A5A,32'h0, 1,4'b0010,32'hA5A5_A5A5,32'h5A5A_5A5A,0);

        // alusrc selection
        step(1,0,0,2'b00,6'b0,1,32'h0000_0005,32'h0000_0003,32'hFFFF_FFFF, 1,4'b0010,32'h0000_0005,32'hFFFF_FFFF,0);
        step(1,0,0,2'b00,6'b0,0,32'h0000_0005,32'h0000_0003,32'hFFFF_FFFF, 1,4'b0010,32'h0000_0005,32'h0000_0003,0);

        // slti class
        step(1,0,0,2'b11,6'b0,1,32'h8000_0000,32'h0,32'h0000_1234, 1,4'b0111,32'h8000_0000,32'h0000_1234,0);

        // Load sub, stall three cycles with changing inputs, then stall+flush
        step(1,0,0,2'b01,6'b0,0,32'h1111_1111,32'h2222_2222,32'h0, 1,4'b0110,32'h1111_1111,32'h2222_2222,0);
        step(0,1,0,2'b10,6'b111111,1,32'hDEAD_BEEF,32'hCAFE_F00D,32'h1357_9BDF, 1,4'b0110,32'h1111_1111,32'h2222_2222,0);
        step(1,1,0,2'b10,6'b100111,0,32'h0BAD_0BAD,32'h0000_0001,32'h0, 1,4'b0110,32'h1111_1111,32'h2222_2222,0);
        step(1,1,0,2'b11,6'b0,1,32'h7777_7777,32'h0,32'h8888_8888, 1,4'b0110,32'h1111_1111,32'h2222_2222,0);
        step(1,1,1,2'b10,6'b100100,0,32'h1234_5678,32'h9ABC_DEF0,32'h0, 0,4'b0010,32'h0,32'h0,0);

        // Invalid slot with illegal funct: flag suppressed, data still loaded
        step(0,0,0,2'b10,6'b111111,0,32'h0000_00AA,32'h0000_00BB,32'h0, 0,4'b0010,32'h0000_00AA,32'h0000_00BB,0);

        // Flush alone with a valid instruction offered
        step(1,0,0,2'b10,6'b100101,0,32'h0000_0F0F,32'h0000_F0F0,32'h0, 1,4'b0001,32'h0000_0F0F,32'h0000_F0F0,0);
        step(1,0,1,2'b10,6'b100101,0,32'h3333_3333,32'h4444_4444,32'h0, 0,4'b0010,32'h0,32'h0,0);

        // Load then reset pulse between edges
        step(1,0,0,2'b10,6'b001000,1,32'hFEDC_BA98,32'h0,32'h7654_3210, 1,4'b0010,32'hFEDC_BA98,32'h7654_3210,1);
        @(negedge clock);
        #2 reset = 1'b0;
        check_now(1'b0, 4'b0010, 32'h0, 32'h0, 1'b0);
        @(negedge clock);
        reset = 1'b1;

        // First load after reset release
        step(1,0,0,2'b10,6'b101010,0,32'h0000_0001,32'h0000_0002,32'h0, 1,4'b0111,32'h0000_0001,32'h0000_0002,0);

        // Drain scoreboard with a bounded wait
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clock);
        #2;
        if (q.size() > 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
